fcdnn_run_scheduler: RTL and testbench
======================================

FCDNN_RUN_SCHEDULER -- requirements
Module: fcdnn_run_scheduler

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk (rising edge) and rst (1 = reset, sampled on clk only).
REQ-002 Ports SHALL be:
- clk  in  1  clock
- rst  in  1  sync active-high reset
- conf_done  in  1  configuration valid (level)
- conf_info_runs  in  32  number of core runs
- conf_info_rd_base  in  32  first DMA read index (64-bit beats)
- conf_info_rd_stride  in  32  read index increment per run
- conf_info_wr_base  in  32  first DMA write index
- conf_info_wr_stride  in  32  write index increment per run
- conf_info_timeout  in  32  max cycles per run; 0 = watchdog off
- run_start  out  1  one-cycle launch pulse to the per-run DMA/Core engine
- run_rd_index  out  32  read index for the launched run
- run_wr_index  out  32  write index for the launched run
- run_id  out  32  zero-based id of the launched run
- run_done  in  1  one-cycle completion pulse from the engine
- acc_done  out  1  one-cycle end-of-job pulse
- debug  out  32  [31] error, [30:0] completed-run count

Function
REQ-003 The FSM SHALL have the states IDLE, LAUNCH, WAIT, DONE and ERR.
REQ-004 IDLE: when conf_done=1 and configured=0, the block SHALL set configured, latch all conf_info_* values, load run_rd_index=rd_base, run_wr_index=wr_base, run_id=0, clear the completed count and debug, then go to DONE if runs==0, else to LAUNCH.
REQ-005 configured SHALL clear only in IDLE while conf_done=0, so each job needs conf_done to deassert and then reassert.
REQ-006 LAUNCH: run_start SHALL be 1 for exactly this single cycle with stable indices and run_id, the watchdog timer SHALL clear to 0, and the next state SHALL be WAIT.
REQ-007 WAIT: the timer SHALL increment by 1 each cycle, saturating at 0xFFFFFFFF.
REQ-008 WAIT, run_done=1: the completed count SHALL increment, with debug[30:0] updated the same cycle. If completed+1==runs the next state SHALL be DONE. Otherwise rd_index+=rd_stride, wr_index+=wr_stride, run_id+=1, and the next state SHALL be LAUNCH.
REQ-009 WAIT, run_done=0, timeout!=0, timer==timeout-1: the next state SHALL be ERR.
REQ-010 When run_done and the timeout condition occur in the same cycle, run_done SHALL win and no error SHALL be flagged.
REQ-011 DONE: acc_done SHALL be 1 for one cycle, debug[31] SHALL be 0, and the next state SHALL be IDLE.
REQ-012 ERR: acc_done SHALL be 1 for one cycle, debug[31] SHALL be 1, debug[30:0] SHALL hold the completed count, and the next state SHALL be IDLE.
REQ-013 Index arithmetic SHALL be unsigned 32-bit and wrap modulo 2^32 without flagging.
REQ-014 run_done in IDLE, LAUNCH, DONE or ERR SHALL be ignored.
REQ-015 Changes to conf_info_* after latching SHALL have no effect until the next job.
REQ-016 The completed count SHALL be 32-bit internally, and debug SHALL expose its low 31 bits.
REQ-017 Minimum latency SHALL be:
- conf_done to first run_start: 2 cycles.
- run_done to next run_start: 1 cycle.
- final run_done to acc_done: 1 cycle.
REQ-018 debug SHALL hold its value after acc_done until the next job latch.

Reset
REQ-019 With rst=1 at a clk edge, the block SHALL set state=IDLE, configured=0, and run_start, acc_done, run_rd_index, run_wr_index, run_id, debug, the timer and the completed count all to 0.
REQ-020 Reset asserted mid-run (LAUNCH or WAIT) SHALL abort the job with no acc_done pulse, and a run_done arriving after reset SHALL be ignored.
REQ-021 After reset deasserts with conf_done still 1, a new job SHALL start on the next cycle, because configured was cleared.

Verification
REQ-022 runs=3, rd_base=0x10, rd_stride=28, wr_base=0x100, wr_stride=15, timeout=0, engine answers run_done 5 cycles after each run_start -> three run_start pulses with (rd,wr,id) = (0x10,0x100,0), (0x2C,0x10F,1), (0x48,0x11E,2); one acc_done; debug=0x00000003.
REQ-023 runs=0 -> no run_start; acc_done exactly 2 cycles after the conf_done edge; debug=0.
REQ-024 runs=2, timeout=8, engine never answers the second run -> ERR; acc_done 8 cycles after the second WAIT entry; debug=0x80000001.
REQ-025 timeout=4, run_done arrives on the cycle where timer==3 -> no error, job completes, debug[31]=0.
REQ-026 rd_base=0xFFFFFFF0, rd_stride=0x20, runs=2 -> second run_rd_index=0x00000010 (wrap), no error.
REQ-027 Assert rst during WAIT of run 1 of 4 -> outputs zero next cycle; late run_done ignored; conf_done held high starts a fresh job from run_id 0.

Source files
------------

// File: rtl/fcdnn_run_scheduler_if.sv
// Job/run handshake bundle for fcdnn_run_scheduler.
//   conf_*      : job configuration from the host (conf_done is a level)
//   run_*       : per-run launch pulse and indices to the DMA/core engine,
//                 run_done is the engine's one-cycle completion pulse
//   acc_done    : one-cycle end-of-job pulse
//   debug       : [31] error, [30:0] completed-run count
// master drives configuration and run_done; slave is the scheduler.
interface fcdnn_run_scheduler_if;
  logic        conf_done;
  logic [31:0] conf_info_runs;
  logic [31:0] conf_info_rd_base;
  logic [31:0] conf_info_rd_stride;
  logic [31:0] conf_info_wr_base;
  logic [31:0] conf_info_wr_stride;
  logic [31:0] conf_info_timeout;
  logic        run_start;
  logic [31:0] run_rd_index;
  logic [31:0] run_wr_index;
  logic [31:0] run_id;
  logic        run_done;
  logic        acc_done;
  logic [31:0] debug;

  modport master (
    output conf_done, conf_info_runs, conf_info_rd_base, conf_info_rd_stride,
           conf_info_wr_base, conf_info_wr_stride, conf_info_timeout, run_done,
    input  run_start, run_rd_index, run_wr_index, run_id, acc_done, debug
  );

  modport slave (
    input  conf_done, conf_info_runs, conf_info_rd_base, conf_info_rd_stride,
           conf_info_wr_base, conf_info_wr_stride, conf_info_timeout, run_done,
    output run_start, run_rd_index, run_wr_index, run_id, acc_done, debug
  );
endinterface

// File: rtl/fcdnn_run_scheduler.sv
// Run scheduler for the FC-DNN accelerator: on each new job it launches
// conf_info_runs core runs back to back, stepping the DMA read/write indices
// by their strides, guards every run with an optional watchdog, and signals
// the end of the job with acc_done.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : fcdnn_run_scheduler_if.slave (configuration, run handshake,
//          acc_done, debug)
// All outputs are registered and are set on the transition into the state
// they belong to, so run_start is high exactly while in LAUNCH and acc_done
// exactly while in DONE/ERR.
module fcdnn_run_scheduler (
  input logic                  clk,
  input logic                  rst,
  fcdnn_run_scheduler_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StLaunch, StWait, StDone, StErr} state_e;

  state_e      state_q, state_d;
  logic        configured_q, configured_d;
  logic [31:0] runs_q, runs_d;
  logic [31:0] rd_stride_q, rd_stride_d;
  logic [31:0] wr_stride_q, wr_stride_d;
  logic [31:0] timeout_q, timeout_d;
  logic [31:0] rd_idx_q, rd_idx_d;
  logic [31:0] wr_idx_q, wr_idx_d;
  logic [31:0] id_q, id_d;
  logic [31:0] timer_q, timer_d;
  logic [31:0] count_q, count_d;
  logic [31:0] debug_q, debug_d;
  logic        run_start_q, run_start_d;
  logic        acc_done_q, acc_done_d;
  logic [31:0] count_inc;

  always_comb begin
    state_d      = state_q;
    configured_d = configured_q;
    runs_d       = runs_q;
    rd_stride_d  = rd_stride_q;
    wr_stride_d  = wr_stride_q;
    timeout_d    = timeout_q;
    rd_idx_d     = rd_idx_q;
    wr_idx_d     = wr_idx_q;
    id_d         = id_q;
    timer_d      = timer_q;
    count_d      = count_q;
    debug_d      = debug_q;
    run_start_d  = 1'b0;
    acc_done_d   = 1'b0;
    count_inc    = count_q + 32'd1;

    unique case (state_q)
      StIdle: begin
        if (!bus.conf_done) begin
          // A job is accepted only on a fresh conf_done level.
          configured_d = 1'b0;
        end else if (!configured_q) begin
          configured_d = 1'b1;
          runs_d       = bus.conf_info_runs;
          rd_stride_d  = bus.conf_info_rd_stride;
          wr_stride_d  = bus.conf_info_wr_stride;
          timeout_d    = bus.conf_info_timeout;
          rd_idx_d     = bus.conf_info_rd_base;
          wr_idx_d     = bus.conf_info_wr_base;
          id_d         = 32'd0;
          count_d      = 32'd0;
          debug_d      = 32'd0;
          if (bus.conf_info_runs == 32'd0) begin
            state_d    = StDone;
            acc_done_d = 1'b1;
          end else begin
            state_d     = StLaunch;
            run_start_d = 1'b1;
          end
        end
      end

      StLaunch: begin
        timer_d = 32'd0;
        state_d = StWait;
      end

      StWait: begin
        if (timer_q != 32'hFFFF_FFFF) begin
          timer_d = timer_q + 32'd1;
        end
        // Completion takes priority over a coincident watchdog expiry.
        if (bus.run_done) begin
          count_d = count_inc;
          debug_d = {1'b0, count_inc[30:0]};
          if (count_inc == runs_q) begin
            state_d    = StDone;
            acc_done_d = 1'b1;
          end else begin
            rd_idx_d    = rd_idx_q + rd_stride_q;
            wr_idx_d    = wr_idx_q + wr_stride_q;
            id_d        = id_q + 32'd1;
            state_d     = StLaunch;
            run_start_d = 1'b1;
          end
        end else if ((timeout_q != 32'd0) && (timer_q == timeout_q - 32'd1)) begin
          state_d    = StErr;
          acc_done_d = 1'b1;
          debug_d    = {1'b1, count_q[30:0]};
        end
      end

      StDone, StErr: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      configured_q <= 1'b0;
      runs_q       <= 32'd0;
      rd_stride_q  <= 32'd0;
      wr_stride_q  <= 32'd0;
      timeout_q    <= 32'd0;
      rd_idx_q     <= 32'd0;
      wr_idx_q     <= 32'd0;
      id_q         <= 32'd0;
      timer_q      <= 32'd0;
      count_q      <= 32'd0;
      debug_q      <= 32'd0;
      run_start_q  <= 1'b0;
      acc_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      configured_q <= configured_d;
      runs_q       <= runs_d;
      rd_stride_q  <= rd_stride_d;
      wr_stride_q  <= wr_stride_d;
      timeout_q    <= timeout_d;
      rd_idx_q     <= rd_idx_d;
      wr_idx_q     <= wr_idx_d;
      id_q         <= id_d;
      timer_q      <= timer_d;
      count_q      <= count_d;
      debug_q      <= debug_d;
      run_start_q  <= run_start_d;
      acc_done_q   <= acc_done_d;
    end
  end

  assign bus.run_start    = run_start_q;
  assign bus.run_rd_index = rd_idx_q;
  assign bus.run_wr_index = wr_idx_q;
  assign bus.run_id       = id_q;
  assign bus.acc_done     = acc_done_q;
  assign bus.debug        = debug_q;

endmodule

// File: tb/tb_fcdnn_run_scheduler.sv
// Self-checking bench for fcdnn_run_scheduler: directed vector table, random
// jobs against a job-level reference model, and a mid-run reset sequence.
// Event times are stamped with the number of the rising edge that samples them.
module tb_fcdnn_run_scheduler;

  logic clk = 1'b0;
  logic rst;

  fcdnn_run_scheduler_if bus ();

  fcdnn_run_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic [31:0] wr;
    logic [31:0] id;
    int          stamp;
  } start_t;

  typedef struct {
    int          stamp;
    logic [31:0] dbg;
    logic [31:0] rd;
    logic [31:0] wr;
  } acc_t;

  typedef struct {
    logic [31:0] runs;
    logic [31:0] rd_base;
    logic [31:0] rd_stride;
    logic [31:0] wr_base;
    logic [31:0] wr_stride;
    logic [31:0] timeout;
    int          dly;        // engine answer delay in cycles after run_start
    int          hang;       // run index the engine never answers, -1 = none
    int          exp_starts;
    logic [31:0] exp_rd;     // run_rd_index while acc_done is high
    logic [31:0] exp_wr;
    logic [31:0] exp_dbg;
    int          exp_tail;   // acc_done stamp minus last run_start stamp (or conf edge)
  } vec_t;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  start_t      starts_q[$];
  acc_t        acc_q[$];
  bit          due[int];
  int          eng_dly[64];
  int          eng_idx = 0;
  start_t      exp_s[$];
  int          exp_acc;
  logic [31:0] exp_dbg;

  always @(posedge clk) cyc <= cyc + 1;

  // Engine model and output monitor, both working at the falling edge.
  initial begin
    start_t s;
    acc_t   a;
    bus.run_done = 1'b0;
    forever begin
      @(negedge clk);
      bus.run_done = due.exists(cyc + 1);
      if (bus.run_start === 1'b1) begin
        s.rd = bus.run_rd_index;
        s.wr = bus.run_wr_index;
        s.id = bus.run_id;
        s.stamp = cyc + 1;
        starts_q.push_back(s);
        if (eng_idx < 64 && eng_dly[eng_idx] > 0) due[cyc + 1 + eng_dly[eng_idx]] = 1'b1;
        eng_idx++;
      end
      if (bus.acc_done === 1'b1) begin
        a.stamp = cyc + 1;
        a.dbg = bus.debug;
        a.rd = bus.run_rd_index;
        a.wr = bus.run_wr_index;
        acc_q.push_back(a);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "global timeout");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic drive_conf(input vec_t v);
    bus.conf_info_runs      = v.runs;
    bus.conf_info_rd_base   = v.rd_base;
    bus.conf_info_rd_stride = v.rd_stride;
    bus.conf_info_wr_base   = v.wr_base;
    bus.conf_info_wr_stride = v.wr_stride;
    bus.conf_info_timeout   = v.timeout;
  endtask

  // Job-level reference: run i starts at a known time with base + i*stride;
  // a run answered within the timeout lets the next one start d+1 cycles later,
  // otherwise the watchdog ends the job timeout+1 cycles after that run_start.
  task automatic model(input vec_t v, input int t0);
    int          t;
    logic [31:0] done;
    bit          err;
    start_t      s;
    exp_s.delete();
    t = t0 + 2;
    done = 32'd0;
    err = 1'b0;
    exp_acc = t0 + 2;
    for (int i = 0; i < int'(v.runs); i++) begin
      s.rd = v.rd_base + v.rd_stride * 32'(i);
      s.wr = v.wr_base + v.wr_stride * 32'(i);
      s.id = 32'(i);
      s.stamp = t;
      exp_s.push_back(s);
      if (v.timeout != 0 && (eng_dly[i] < 0 || eng_dly[i] > int'(v.timeout))) begin
        err = 1'b1;
        exp_acc = t + int'(v.timeout) + 1;
        break;
      end
      done = done + 32'd1;
      t = t + eng_dly[i] + 1;
      exp_acc = t;
    end
    exp_dbg = {err, done[30:0]};
  endtask

  task automatic do_job(input vec_t v, input bit drive, input int t0_in, input string tag,
                        output int n_st, output int tail, output logic [31:0] dbg,
                        output logic [31:0] rd, output logic [31:0] wr);
    int t0;
    int n;
    eng_idx = 0;
    starts_q.delete();
    acc_q.delete();
    if (drive) begin
      @(posedge clk);
      #1;
      drive_conf(v);
      bus.conf_done = 1'b1;
      t0 = cyc;
    end else begin
      t0 = t0_in;
    end
    model(v, t0);
    while (acc_q.size() == 0 && cyc < t0 + 400) begin
      @(posedge clk);
      #1;
      // Latched configuration must be immune to later changes.
      bus.conf_info_runs      = $urandom;
      bus.conf_info_rd_base   = $urandom;
      bus.conf_info_rd_stride = $urandom;
      bus.conf_info_wr_base   = $urandom;
      bus.conf_info_wr_stride = $urandom;
      bus.conf_info_timeout   = $urandom;
    end
    // conf_done stays high here: no second job may start.
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    n_st = starts_q.size();
    chk({tag, "_start_count"}, 32'(n_st), 32'(exp_s.size()));
    n = (n_st < exp_s.size()) ? n_st : exp_s.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_run%0d_rd", tag, i), starts_q[i].rd, exp_s[i].rd);
      chk($sformatf("%s_run%0d_wr", tag, i), starts_q[i].wr, exp_s[i].wr);
      chk($sformatf("%s_run%0d_id", tag, i), starts_q[i].id, exp_s[i].id);
      chk($sformatf("%s_run%0d_time", tag, i), 32'(starts_q[i].stamp), 32'(exp_s[i].stamp));
    end
    chk({tag, "_acc_count"}, 32'(acc_q.size()), 32'd1);
    if (acc_q.size() > 0) begin
      chk({tag, "_acc_time"}, 32'(acc_q[0].stamp), 32'(exp_acc));
      chk({tag, "_acc_debug"}, acc_q[0].dbg, exp_dbg);
      dbg = acc_q[0].dbg;
      rd = acc_q[0].rd;
      wr = acc_q[0].wr;
      tail = (n_st > 0) ? acc_q[0].stamp - starts_q[n_st - 1].stamp : acc_q[0].stamp - t0;
    end else begin
      dbg = 32'hDEAD_BEEF;
      rd = 32'hDEAD_BEEF;
      wr = 32'hDEAD_BEEF;
      tail = -1;
    end
    chk({tag, "_debug_hold"}, bus.debug, exp_dbg);
    bus.conf_done = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_run_start"}, 32'(bus.run_start), 32'd0);
    chk({tag, "_acc_done"}, 32'(bus.acc_done), 32'd0);
    chk({tag, "_rd_index"}, bus.run_rd_index, 32'd0);
    chk({tag, "_wr_index"}, bus.run_wr_index, 32'd0);
    chk({tag, "_run_id"}, bus.run_id, 32'd0);
    chk({tag, "_debug"}, bus.debug, 32'd0);
  endtask

  vec_t tbl[7];

  initial begin
    vec_t        v;
    int          n_st;
    int          tail;
    int          t0;
    int          d;
    logic [31:0] dbg;
    logic [31:0] rd;
    logic [31:0] wr;

    //         runs  rd_base        rd_str  wr_base        wr_str  tmo  dly hang st rd            wr            debug          tail
    tbl[0] = '{32'd3, 32'h10,       32'd28, 32'h100,       32'd15, 32'd0, 5, -1, 3, 32'h48,       32'h11E,      32'h0000_0003, 6};
    tbl[1] = '{32'd0, 32'h55,       32'd4,  32'h66,        32'd4,  32'd0, 5, -1, 0, 32'h55,       32'h66,       32'h0000_0000, 2};
    // ERR is entered 8 cycles after WAIT entry; acc_done is sampled one edge later.
    tbl[2] = '{32'd2, 32'h200,      32'd4,  32'h300,       32'd8,  32'd8, 3,  1, 2, 32'h204,      32'h308,      32'h8000_0001, 9};
    tbl[3] = '{32'd2, 32'h0,        32'd1,  32'h0,         32'd2,  32'd4, 4, -1, 2, 32'h1,        32'h2,        32'h0000_0002, 5};
    tbl[4] = '{32'd2, 32'hFFFF_FFF0, 32'h20, 32'hFFFF_FFFF, 32'd1,  32'd0, 2, -1, 2, 32'h10,       32'h0,        32'h0000_0002, 3};
    tbl[5] = '{32'd1, 32'h40,       32'd8,  32'h80,        32'd8,  32'd4, 5, -1, 1, 32'h40,       32'h80,       32'h8000_0000, 5};
    tbl[6] = '{32'd3, 32'h7,        32'd1,  32'h9,         32'd2,  32'd1, 1, -1, 3, 32'h9,        32'hD,        32'h0000_0003, 2};

    rst = 1'b1;
    bus.conf_done = 1'b0;
    v = tbl[1];
    drive_conf(v);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int k = 0; k < 7; k++) begin
      for (int i = 0; i < 64; i++) eng_dly[i] = tbl[k].dly;
      if (tbl[k].hang >= 0) eng_dly[tbl[k].hang] = -1;
      do_job(tbl[k], 1'b1, 0, $sformatf("tbl%0d", k), n_st, tail, dbg, rd, wr);
      chk($sformatf("tbl%0d_starts", k), 32'(n_st), 32'(tbl[k].exp_starts));
      chk($sformatf("tbl%0d_rd_at_acc", k), rd, tbl[k].exp_rd);
      chk($sformatf("tbl%0d_wr_at_acc", k), wr, tbl[k].exp_wr);
      chk($sformatf("tbl%0d_debug", k), dbg, tbl[k].exp_dbg);
      chk($sformatf("tbl%0d_tail", k), 32'(tail), 32'(tbl[k].exp_tail));
    end

    for (int j = 0; j < 25; j++) begin
      v.runs      = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 6));
      v.rd_base   = $urandom;
      v.rd_stride = $urandom;
      v.wr_base   = $urandom;
      v.wr_stride = $urandom;
      v.timeout   = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'($urandom_range(2, 10));
      for (int i = 0; i < 64; i++) begin
        d = int'($urandom_range(1, 12));
        // A late answer would spill into the next job, so model it as none.
        if (v.timeout != 0 && d > int'(v.timeout)) d = -1;
        eng_dly[i] = d;
      end
      do_job(v, 1'b1, 0, $sformatf("rnd%0d", j), n_st, tail, dbg, rd, wr);
    end

    // Reset during WAIT of the first of four runs, conf_done held high.
    v = tbl[0];
    v.runs = 32'd4;
    for (int i = 0; i < 64; i++) eng_dly[i] = 5;
    eng_idx = 0;
    starts_q.delete();
    acc_q.delete();
    @(posedge clk);
    #1;
    drive_conf(v);
    bus.conf_done = 1'b1;
    t0 = cyc;
    while (starts_q.size() == 0 && cyc < t0 + 50) begin
      @(posedge clk);
      #1;
    end
    chk("rst_first_start_seen", 32'(starts_q.size()), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_zero("midrun_reset");
    // Held for four edges so the pending run_done lands while in IDLE.
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_no_acc", 32'(acc_q.size()), 32'd0);
    drive_conf(v);
    do_job(v, 1'b0, cyc, "post_reset", n_st, tail, dbg, rd, wr);
    chk("post_reset_debug", dbg, 32'h0000_0004);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
